// File: rtl/serial_adder_scheduler_if.sv
// Client-side bundle for serial_adder_scheduler: two requesters' operands,
// request lines and the shared result/status outputs.
interface serial_adder_scheduler_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             cin0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output req, a0, b0, cin0, a1, b1, cin1,
    input  gnt, busy, done, sum, cout
  );

  modport slave (
    input  req, a0, b0, cin0, a1, b1, cin1,
    output gnt, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_scheduler.sv
// Bit-serial adder shared by two requesters: round-robin arbiter plus a Moore
// FSM driving one full-adder cell, LSB first, one bit per clock.

module sas_full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

module serial_adder_scheduler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_adder_scheduler_if.slave bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             full_sum;
  logic             full_carry;
  logic [WIDTH-1:0] sum_sh_next;
  logic             win;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;

  sas_full_adder u_fa (
    .x (a_sh_q[0]),
    .y (b_sh_q[0]),
    .z (carry_q),
    .s (full_sum),
    .c (full_carry)
  );

  // New bit enters at the MSB; written this way so WIDTH = 1 needs no special case
  assign sum_sh_next = (sum_sh_q >> 1) | (WIDTH'(full_sum) << (WIDTH - 1));

  // Round-robin winner: a lone request wins outright, a tie goes to ptr_q
  always_comb begin
    win = 1'b0;
    unique case (bus.req)
      2'b10:   win = 1'b1;
      2'b11:   win = ptr_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    a_sel   = gnt_q[1] ? bus.a1   : bus.a0;
    b_sel   = gnt_q[1] ? bus.b1   : bus.b0;
    cin_sel = gnt_q[1] ? bus.cin1 : bus.cin0;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.req != 2'b00) begin
          state_d = LOAD;
          gnt_d   = win ? 2'b10 : 2'b01;
          ptr_d   = ~win;
        end else begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      LOAD: begin
        a_sh_d  = a_sel;
        b_sh_d  = b_sel;
        carry_d = cin_sel;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sum_sh_d = sum_sh_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = full_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_sh_next;
          cout_d  = full_carry;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the next-state decode
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      ptr_q    <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder_scheduler.md
# serial_adder_scheduler

Bit-serial addition engine that time-shares a single instance of the team's full-adder cell between two requesters. It serves one WIDTH-bit addition at a time, least-significant bit first, one bit per clock. A round-robin arbiter decides which requester is served and a Moore FSM sequences each job. It sits between two client blocks and the shared full-adder datapath, replacing two parallel ripple adders with one cell plus control.

## Interface
- WIDTH, 8, operand and result width in bits; legal values are 1 and above.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req  in  2  per-requester request; bit i belongs to requester i.
- a0, b0  in  WIDTH each  requester 0 operands.
- cin0  in  1  requester 0 carry-in.
- a1, b1  in  WIDTH each  requester 1 operands.
- cin1  in  1  requester 1 carry-in.
- gnt  out  2  one-hot grant, registered; zero when no job is active.
- busy  out  1  high in every state except IDLE.
- done  out  1  high for exactly one cycle per job, while the FSM is in DONE.
- sum  out  WIDTH  result of the most recent completed job, registered.
- cout  out  1  carry-out of the most recent completed job, registered.

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT and DONE.
- Shared cell connections:
  - x = a_sh[0], y = b_sh[0], z = carry.
  - full_sum is shifted into sum_sh; full_carry goes to carry.
- Arbitration:
  - Sampled at an edge in IDLE or DONE when req != 0.
  - A single active request is granted directly.
  - If both requests are active, the requester with the priority pointer wins.
  - On each grant, the pointer moves to the other requester.
  - The pointer resets to requester 0.
- IDLE:
  - If req != 0, go to LOAD and set gnt to the winner.
  - Otherwise stay in IDLE with gnt = 0.
- LOAD:
  - Capture the winner's operands: a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0.
  - Go to SHIFT.
- SHIFT, on every edge:
  - sum_sh <= {full_sum, sum_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - carry <= full_carry, cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1, also load sum <= {full_sum, sum_sh[WIDTH-1:1]} and cout <= full_carry, then go to DONE.
- DONE:
  - done = 1 and gnt still shows the served requester.
  - If req != 0, arbitrate and go straight to LOAD (back-to-back service).
  - Otherwise go to IDLE and set gnt to 0.
- Requesters may drop req or change operands after the LOAD cycle; these changes do not affect the job in flight.
- If req is still high during DONE, it counts as a new request.
- sum and cout hold their value until the next job completes. They are not cleared when the FSM returns to IDLE.
- Arithmetic is {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1).
- cnt width is clog2(WIDTH) bits, with a minimum of 1.

## Timing
- Reset values: state = IDLE, gnt = 0, busy = 0, done = 0, sum = 0, cout = 0, pointer = requester 0, all internal registers = 0.
- Reset has priority over every transition, including in the middle of SHIFT. A job aborted by reset produces no done and leaves sum at 0.
- Latency: if req is sampled at edge E0, then:
  - LOAD occupies the cycle after E0.
  - SHIFT occupies the next WIDTH cycles.
  - done is high during cycle WIDTH+2 after E0.
- Back-to-back jobs take WIDTH+2 cycles each with no IDLE gap.
- busy rises in the cycle after E0 and stays high through DONE.
- For WIDTH = 1, SHIFT lasts exactly one cycle.

## Test plan
- Single add, WIDTH = 8, requester 0: a0 = 0x5A, b0 = 0x33, cin0 = 0, req = 01 for one cycle.
  - Required: gnt = 01, done in cycle 10 after the sample edge, sum = 0x8D, cout = 0.
- Carry chain, requester 1: a1 = 0xFF, b1 = 0x01, cin1 = 0.
  - Required: sum = 0x00, cout = 1.
  - Repeat with a1 = 0xFF, b1 = 0x00, cin1 = 1; required: sum = 0x00, cout = 1.
- Contention after reset: req = 11 held, requester 0 computes 0x10 + 0x20 and requester 1 computes 0x7F + 0x7F.
  - Required: first job granted 01 with sum 0x30; second job granted 10 with sum 0xFE, cout 0.
  - done pulses at cycles 10 and 20 with no IDLE gap.
  - Third grant returns to 01 if req is still 11.
- Reset mid-job: deassert rst_n during the 4th SHIFT cycle.
  - Required: next cycle state is IDLE, gnt = 0, busy = 0, sum = 0, no done pulse.
  - A new request afterwards completes correctly.
- Operand change after LOAD: alter a0 and drop req during SHIFT.
  - Required: result matches the operands captured at LOAD.
- WIDTH = 1 build: a = 1, b = 1, cin = 1.
  - Required: sum = 1, cout = 1, done in cycle 3.
